// File: rtl/calc_req_sequencer.sv
// Calculator request sequencer: runs one test at a time on NUM_PORTS request ports,
// waits for the DUV response (or a timeout), settles, then reports a completed-test record.

module calc_port_drv #(
    parameter int DATA_W = 32
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic              drv_en,
    input  logic [3:0]        drv_cmd,
    input  logic [DATA_W-1:0] drv_data,
    output logic [3:0]        cmd_out,
    output logic [DATA_W-1:0] data_out
);
    logic [3:0]        cmd_q, cmd_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Idle ports fall back to NOP with a zero operand bus.
    always_comb begin
        cmd_d  = drv_en ? drv_cmd  : 4'd0;
        data_d = drv_en ? drv_data : '0;
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            cmd_q  <= '0;
            data_q <= '0;
        end else begin
            cmd_q  <= cmd_d;
            data_q <= data_d;
        end
    end

    assign cmd_out  = cmd_q;
    assign data_out = data_q;
endmodule

module calc_req_sequencer #(
    parameter int                   NUM_PORTS       = 4,
    parameter int                   DATA_W          = 32,
    parameter int                   SETTLE_CYC      = 3,
    parameter int                   TIMEOUT_CYC     = 16,
    parameter logic [NUM_PORTS-1:0] ARITH_SKIP_MASK = '0,
    localparam int                  PORT_W          = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                          c_clk,
    input  logic                          reset,
    input  logic                          stim_valid,
    output logic                          stim_ready,
    input  logic [PORT_W-1:0]             stim_port,
    input  logic [3:0]                    stim_cmd,
    input  logic [DATA_W-1:0]             stim_arg1,
    input  logic [DATA_W-1:0]             stim_arg2,
    output logic [NUM_PORTS*4-1:0]        req_cmd_out,
    output logic [NUM_PORTS*DATA_W-1:0]   req_data_out,
    input  logic [NUM_PORTS*2-1:0]        out_resp,
    input  logic [NUM_PORTS*DATA_W-1:0]   out_data,
    output logic                          rsp_valid,
    output logic [PORT_W-1:0]             rsp_port,
    output logic [1:0]                    rsp_code,
    output logic [DATA_W-1:0]             rsp_data,
    output logic                          rsp_skip,
    output logic                          rsp_timeout,
    output logic                          test_change
);
    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;

    localparam int TO_LAST = (TIMEOUT_CYC > 1) ? TIMEOUT_CYC - 1 : 0;
    localparam int ST_LAST = (SETTLE_CYC > 1) ? SETTLE_CYC - 1 : 0;
    localparam int WCNT_W  = $clog2(TO_LAST + 2);
    localparam int SCNT_W  = $clog2(ST_LAST + 2);
    localparam logic [WCNT_W-1:0] TO_LAST_C = WCNT_W'(TO_LAST);
    localparam logic [SCNT_W-1:0] ST_LAST_C = SCNT_W'(ST_LAST);

    typedef enum logic [2:0] {IDLE, CMD, DATA, WAIT, SETTLE} state_t;

    typedef struct packed {
        logic [PORT_W-1:0] port;
        logic [1:0]        code;
        logic [DATA_W-1:0] data;
        logic              skip;
        logic              timeout;
    } rsp_t;

    state_t              state_q, state_d;
    logic [PORT_W-1:0]   port_q, port_d;
    logic [DATA_W-1:0]   arg2_q, arg2_d;
    logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [SCNT_W-1:0]   settle_cnt_q, settle_cnt_d;
    rsp_t                cap_q, cap_d;
    rsp_t                rsp_q, rsp_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                test_change_q, test_change_d;

    logic                drv_any;
    logic [PORT_W-1:0]   drv_port;
    logic [3:0]          drv_cmd;
    logic [DATA_W-1:0]   drv_data;
    logic [NUM_PORTS-1:0] drv_en;

    logic [NUM_PORTS-1:0][1:0]        resp_arr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] rdata_arr;
    logic [NUM_PORTS-1:0][3:0]        cmd_arr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] data_arr;
    logic                             stim_skip;

    assign resp_arr  = out_resp;
    assign rdata_arr = out_data;

    // Out-of-range ports and masked arithmetic never reach the bus.
    assign stim_skip = (32'(stim_port) >= NUM_PORTS) ||
                       (((stim_cmd == CMD_ADD) || (stim_cmd == CMD_SUB)) && ARITH_SKIP_MASK[stim_port]);

    always_comb begin
        state_d       = state_q;
        port_d        = port_q;
        arg2_d        = arg2_q;
        wait_cnt_d    = wait_cnt_q;
        settle_cnt_d  = settle_cnt_q;
        cap_d         = cap_q;
        rsp_d         = rsp_q;
        rsp_valid_d   = 1'b0;
        test_change_d = test_change_q;
        drv_any       = 1'b0;
        drv_port      = port_q;
        drv_cmd       = CMD_NOP;
        drv_data      = '0;
        case (state_q)
            IDLE: if (stim_valid) begin
                port_d = stim_port;
                arg2_d = stim_arg2;
                if (stim_skip) begin
                    rsp_valid_d   = 1'b1;
                    test_change_d = ~test_change_q;
                    rsp_d = '{port: stim_port, code: 2'd0, data: '0, skip: 1'b1, timeout: 1'b0};
                end else begin
                    state_d  = CMD;
                    drv_any  = 1'b1;
                    drv_port = stim_port;
                    drv_cmd  = stim_cmd;
                    drv_data = stim_arg1;
                end
            end
            CMD: begin
                state_d  = DATA;
                drv_any  = 1'b1;
                drv_data = arg2_q;
            end
            DATA: begin
                state_d    = WAIT;
                wait_cnt_d = '0;
            end
            WAIT: begin
                // A response on the expiring cycle beats the timeout.
                if (resp_arr[port_q] != 2'd0) begin
                    state_d      = SETTLE;
                    settle_cnt_d = '0;
                    cap_d = '{port: port_q, code: resp_arr[port_q], data: rdata_arr[port_q],
                              skip: 1'b0, timeout: 1'b0};
                end else if (wait_cnt_q == TO_LAST_C) begin
                    state_d      = SETTLE;
                    settle_cnt_d = '0;
                    cap_d = '{port: port_q, code: 2'd0, data: '0, skip: 1'b0, timeout: 1'b1};
                end else if (wait_cnt_q != '1) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            SETTLE: begin
                if (settle_cnt_q == ST_LAST_C) begin
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_d         = cap_q;
                    test_change_d = ~test_change_q;
                end else if (settle_cnt_q != '1) begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            port_q        <= '0;
            arg2_q        <= '0;
            wait_cnt_q    <= '0;
            settle_cnt_q  <= '0;
            cap_q         <= '0;
            rsp_q         <= '0;
            rsp_valid_q   <= 1'b0;
            test_change_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            port_q        <= port_d;
            arg2_q        <= arg2_d;
            wait_cnt_q    <= wait_cnt_d;
            settle_cnt_q  <= settle_cnt_d;
            cap_q         <= cap_d;
            rsp_q         <= rsp_d;
            rsp_valid_q   <= rsp_valid_d;
            test_change_q <= test_change_d;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign drv_en[p] = drv_any && (drv_port == PORT_W'(p));

        calc_port_drv #(.DATA_W(DATA_W)) u_drv (
            .c_clk    (c_clk),
            .reset    (reset),
            .drv_en   (drv_en[p]),
            .drv_cmd  (drv_cmd),
            .drv_data (drv_data),
            .cmd_out  (cmd_arr[p]),
            .data_out (data_arr[p])
        );
    end

    assign req_cmd_out  = cmd_arr;
    assign req_data_out = data_arr;
    assign stim_ready   = (state_q == IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_port     = rsp_q.port;
    assign rsp_code     = rsp_q.code;
    assign rsp_data     = rsp_q.data;
    assign rsp_skip     = rsp_q.skip;
    assign rsp_timeout  = rsp_q.timeout;
    assign test_change  = test_change_q;
endmodule

// File: tb/tb_calc_req_sequencer.sv
// Bench for calc_req_sequencer: a 4x32 instance (port 3 arithmetic masked) and an 8x64
// instance with SETTLE_CYC=0, both checked cycle by cycle against a timeline model.

module tb_calc_req_sequencer;
    logic c_clk = 1'b0;
    logic reset = 1'b1;
    always #5 c_clk = ~c_clk;

    logic             n_valid = 1'b0, w_valid = 1'b0;
    logic             n_ready, w_ready;
    logic [2:0]       stim_port = '0;
    logic [3:0]       stim_cmd  = '0;
    logic [63:0]      stim_arg1 = '0, stim_arg2 = '0;
    logic [7:0][1:0]  resp_arr  = '0;
    logic [7:0][63:0] rdata_arr = '0;

    logic [3:0][31:0] n_odata;
    logic [3:0][3:0]  n_cmd;
    logic [3:0][31:0] n_data;
    logic             n_rv, n_skip, n_to, n_tc;
    logic [1:0]       n_port, n_code;
    logic [31:0]      n_rdata;

    logic [7:0][3:0]  w_cmd;
    logic [7:0][63:0] w_data;
    logic             w_rv, w_skip, w_to, w_tc;
    logic [2:0]       w_port;
    logic [1:0]       w_code;
    logic [63:0]      w_rdata;

    for (genvar i = 0; i < 4; i++) begin : g_nd
        assign n_odata[i] = rdata_arr[i][31:0];
    end

    calc_req_sequencer #(.NUM_PORTS(4), .DATA_W(32), .SETTLE_CYC(3), .TIMEOUT_CYC(16),
                         .ARITH_SKIP_MASK(4'b1000)) dut (
        .c_clk(c_clk), .reset(reset), .stim_valid(n_valid), .stim_ready(n_ready),
        .stim_port(stim_port[1:0]), .stim_cmd(stim_cmd), .stim_arg1(stim_arg1[31:0]),
        .stim_arg2(stim_arg2[31:0]), .req_cmd_out(n_cmd), .req_data_out(n_data),
        .out_resp(resp_arr[3:0]), .out_data(n_odata), .rsp_valid(n_rv), .rsp_port(n_port),
        .rsp_code(n_code), .rsp_data(n_rdata), .rsp_skip(n_skip), .rsp_timeout(n_to),
        .test_change(n_tc));

    calc_req_sequencer #(.NUM_PORTS(8), .DATA_W(64), .SETTLE_CYC(0), .TIMEOUT_CYC(4),
                         .ARITH_SKIP_MASK(8'h00)) dut_w (
        .c_clk(c_clk), .reset(reset), .stim_valid(w_valid), .stim_ready(w_ready),
        .stim_port(stim_port), .stim_cmd(stim_cmd), .stim_arg1(stim_arg1),
        .stim_arg2(stim_arg2), .req_cmd_out(w_cmd), .req_data_out(w_data),
        .out_resp(resp_arr), .out_data(rdata_arr), .rsp_valid(w_rv), .rsp_port(w_port),
        .rsp_code(w_code), .rsp_data(w_rdata), .rsp_skip(w_skip), .rsp_timeout(w_to),
        .test_change(w_tc));

    int n_chk = 0;
    int n_fail = 0;

    logic [63:0] ex_port[2], ex_code[2], ex_data[2];
    logic        ex_skip[2], ex_to[2], ex_tc[2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] o_cmd(input int sel, input int p);
        if (sel != 0) return 64'(w_cmd[p]);
        return 64'(n_cmd[p]);
    endfunction

    function automatic logic [63:0] o_data(input int sel, input int p);
        if (sel != 0) return w_data[p];
        return 64'(n_data[p]);
    endfunction

    // f: 0 valid, 1 port, 2 code, 3 data, 4 skip, 5 timeout, 6 test_change, 7 ready
    function automatic logic [63:0] o_rsp(input int sel, input int f);
        case (f)
            0: return 64'(sel ? w_rv : n_rv);
            1: return sel ? 64'(w_port) : 64'(n_port);
            2: return sel ? 64'(w_code) : 64'(n_code);
            3: return sel ? w_rdata : 64'(n_rdata);
            4: return 64'(sel ? w_skip : n_skip);
            5: return 64'(sel ? w_to : n_to);
            6: return 64'(sel ? w_tc : n_tc);
            default: return 64'(sel ? w_ready : n_ready);
        endcase
    endfunction

    task automatic chk_rec(input int sel, input string pfx);
        chk({pfx, " rsp_port"},    o_rsp(sel, 1), ex_port[sel]);
        chk({pfx, " rsp_code"},    o_rsp(sel, 2), ex_code[sel]);
        chk({pfx, " rsp_data"},    o_rsp(sel, 3), ex_data[sel]);
        chk({pfx, " rsp_skip"},    o_rsp(sel, 4), 64'(ex_skip[sel]));
        chk({pfx, " rsp_timeout"}, o_rsp(sel, 5), 64'(ex_to[sel]));
        chk({pfx, " test_change"}, o_rsp(sel, 6), 64'(ex_tc[sel]));
    endtask

    task automatic clear_model();
        for (int s = 0; s < 2; s++) begin
            ex_port[s] = '0; ex_code[s] = '0; ex_data[s] = '0;
            ex_skip[s] = 1'b0; ex_to[s] = 1'b0; ex_tc[s] = 1'b0;
        end
    endtask

    task automatic chk_all_zero(input string pfx);
        for (int s = 0; s < 2; s++) begin
            for (int p = 0; p < (s ? 8 : 4); p++) begin
                chk($sformatf("%s s%0d p%0d cmd", pfx, s, p), o_cmd(s, p), 64'd0);
                chk($sformatf("%s s%0d p%0d data", pfx, s, p), o_data(s, p), 64'd0);
            end
            chk($sformatf("%s s%0d rsp_valid", pfx, s), o_rsp(s, 0), 64'd0);
            chk_rec(s, $sformatf("%s s%0d", pfx, s));
        end
    endtask

    // Timeline model: handshake in cycle 0, CMD cycle 1, DATA cycle 2, WAIT cycle j is
    // cycle j+2, and the record appears max(SETTLE,1) cycles after the last WAIT cycle.
    task automatic run_test(input int sel, input int port, input logic [3:0] cmd,
                            input logic [63:0] a1, input logic [63:0] a2, input int rsp_at,
                            input logic [1:0] code, input logic [63:0] val, input bit noise,
                            input int rst_at);
        int np, s, t, w, total, q;
        logic [7:0]  mask;
        logic [63:0] dm, ec, ed;
        bit skip, hit;
        string pfx;
        np   = sel ? 8 : 4;
        s    = sel ? 0 : 3;
        t    = sel ? 4 : 16;
        mask = sel ? 8'h00 : 8'h08;
        dm   = sel ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        skip = ((cmd == 4'd1) || (cmd == 4'd2)) && mask[port];
        hit  = (rsp_at >= 1) && (rsp_at <= t);
        w    = hit ? rsp_at : t;
        total = skip ? 1 : 3 + w + ((s > 0) ? s : 1);

        @(negedge c_clk);
        stim_port = 3'(port); stim_cmd = cmd; stim_arg1 = a1; stim_arg2 = a2;
        if (sel != 0) w_valid = 1'b1; else n_valid = 1'b1;
        pfx = $sformatf("s%0d p%0d c%0d k0", sel, port, cmd);
        chk({pfx, " stim_ready"}, o_rsp(sel, 7), 64'd1);
        chk({pfx, " rsp_valid"},  o_rsp(sel, 0), 64'd0);

        for (int k = 1; k <= total; k++) begin
            @(negedge c_clk);
            n_valid = 1'b0; w_valid = 1'b0; resp_arr = '0; rdata_arr = '0;
            pfx = $sformatf("s%0d p%0d c%0d k%0d", sel, port, cmd, k);
            if (k == total) begin
                ex_port[sel] = 64'(port);
                ex_skip[sel] = skip;
                ex_to[sel]   = !skip && !hit;
                ex_code[sel] = (!skip && hit) ? 64'(code) : 64'd0;
                ex_data[sel] = (!skip && hit) ? (val & dm) : 64'd0;
                ex_tc[sel]   = ~ex_tc[sel];
            end
            for (int p = 0; p < np; p++) begin
                ec = '0; ed = '0;
                if (!skip && p == port && k == 1) begin ec = 64'(cmd); ed = a1 & dm; end
                if (!skip && p == port && k == 2) ed = a2 & dm;
                chk($sformatf("%s drv%0d cmd", pfx, p),  o_cmd(sel, p),  ec);
                chk($sformatf("%s drv%0d data", pfx, p), o_data(sel, p), ed);
            end
            chk({pfx, " rsp_valid"},  o_rsp(sel, 0), 64'(k == total));
            chk({pfx, " stim_ready"}, o_rsp(sel, 7), 64'(skip || k == total));
            chk_rec(sel, pfx);

            if (k == rst_at) begin
                #1 reset = 1'b1;
                #1 clear_model();
                chk_all_zero({pfx, " in reset"});
                @(negedge c_clk);
                reset = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    @(negedge c_clk);
                    chk($sformatf("%s post-reset%0d rsp_valid", pfx, j), o_rsp(sel, 0), 64'd0);
                    chk($sformatf("%s post-reset%0d ready", pfx, j),     o_rsp(sel, 7), 64'd1);
                end
                return;
            end

            if (!skip) begin
                if (noise && $urandom_range(2) == 0) begin
                    q = (port + 1 + int'($urandom_range(np - 2))) % np;
                    resp_arr[q]  = 2'($urandom_range(3, 1));
                    rdata_arr[q] = {$urandom, $urandom};
                end
                if (rsp_at > 0 && k - 2 == rsp_at) begin
                    resp_arr[port]  = code;
                    rdata_arr[port] = val;
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] cmds[5];
        int sel, np, t;
        cmds[0] = 4'd0; cmds[1] = 4'd1; cmds[2] = 4'd2; cmds[3] = 4'd5; cmds[4] = 4'd6;
        clear_model();
        repeat (2) @(negedge c_clk);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge c_clk);
        chk("release n ready", o_rsp(0, 7), 64'd1);
        chk("release w ready", o_rsp(1, 7), 64'd1);

        run_test(0, 0, 4'd1, 64'hFFFF_0000, 64'h0000_FFFF, 2, 2'd1, 64'hFFFF_FFFF, 1'b0, -1);
        run_test(0, 3, 4'd2, 64'h1234, 64'h5678, 2, 2'd1, 64'h9, 1'b0, -1);
        run_test(0, 2, 4'd5, 64'hFFFF_FFFF, 64'd32, 0, 2'd0, 64'd0, 1'b1, -1);
        run_test(0, 1, 4'd6, 64'hAAAA_5555, 64'd4, 16, 2'd2, 64'h0BAD_CAFE, 1'b1, -1);
        run_test(0, 1, 4'd6, 64'hAAAA_5555, 64'd4, 17, 2'd2, 64'h0BAD_CAFE, 1'b0, -1);
        run_test(0, 3, 4'd5, 64'h1, 64'h2, 1, 2'd3, 64'h7777_0001, 1'b0, -1);
        run_test(0, 1, 4'd1, 64'h1111_2222, 64'h3333_4444, 5, 2'd1, 64'h1, 1'b0, 2);
        run_test(0, 1, 4'd1, 64'h1111_2222, 64'h3333_4444, 3, 2'd1, 64'h4444_6666, 1'b0, -1);
        run_test(0, 0, 4'd0, 64'h0, 64'h0, 0, 2'd0, 64'h0, 1'b0, -1);
        run_test(1, 7, 4'd6, 64'h8000_0000_0000_0000, 64'd63, 2, 2'd3,
                 64'hDEAD_BEEF_0123_4567, 1'b1, -1);
        run_test(1, 3, 4'd2, 64'h5, 64'h3, 0, 2'd0, 64'h0, 1'b0, -1);
        run_test(1, 0, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 4, 2'd2, 64'h8000_0000_0000_0001,
                 1'b0, -1);

        for (int i = 0; i < 24; i++) begin
            sel = int'($urandom_range(1));
            np  = sel ? 8 : 4;
            t   = sel ? 4 : 16;
            run_test(sel, int'($urandom_range(np - 1)), cmds[$urandom_range(4)],
                     {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(t + 2)),
                     2'($urandom_range(3, 1)), {$urandom, $urandom}, 1'b1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
